// File: rtl/jmb_horz_decim_by_2_pkg.sv
// Shared definitions for the horizontal by-2 decimator: state encoding and
// default stream geometry.
package jmb_horz_decim_by_2_pkg;

  typedef enum logic {
    S_EVEN = 1'b0,
    S_ODD  = 1'b1
  } state_t;

  localparam int JMB_PIX_W  = 8;
  localparam int JMB_LINE_W = 640;

endpackage

// File: rtl/jmb_pair_avg.sv
// Combinational mean of two pixels, optionally rounding half up. Shared with
// the vertical decimator.
module jmb_pair_avg #(
  parameter int DATA_W = 8,
  parameter int ROUND  = 1
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] avg
);

  logic [DATA_W:0] sum;

  // One extra bit holds the carry; after the shift the mean always fits DATA_W.
  assign sum = {1'b0, a} + {1'b0, b} + (DATA_W + 1)'(ROUND);
  assign avg = DATA_W'(sum >> 1);

endmodule

// File: rtl/jmb_horz_decim_by_2.sv
// Horizontal 2:1 pixel decimator: averages adjacent pixel pairs of each line,
// with valid/ready on both sides and an optional line-length check.
module jmb_horz_decim_by_2
  import jmb_horz_decim_by_2_pkg::*;
#(
  parameter int DATA_W = JMB_PIX_W,
  parameter int ROUND  = 1,
  parameter int LINE_W = JMB_LINE_W,
  parameter int CNT_W  = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [DATA_W-1:0] data_in,
  input  logic              last_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [DATA_W-1:0] data_out,
  output logic              last_out,
  output logic              line_err
);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] pair_mean;
  logic              accept;
  logic              take_even;
  logic              produce;

  assign ready_out = !valid_out || ready_in;
  assign accept    = valid_in && ready_out;

  jmb_pair_avg #(
    .DATA_W (DATA_W),
    .ROUND  (ROUND)
  ) u_pair_avg (
    .a   (hold),
    .b   (data_in),
    .avg (pair_mean)
  );

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    take_even = 1'b0;
    produce   = 1'b0;
    if (accept) begin
      case (state)
        S_EVEN: begin
          if (last_in) begin
            produce = 1'b1;
          end else begin
            take_even = 1'b1;
            state_nxt = S_ODD;
          end
        end
        S_ODD: begin
          produce   = 1'b1;
          state_nxt = S_EVEN;
        end
        default: state_nxt = S_EVEN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_EVEN;
      hold  <= '0;
    end else begin
      state <= state_nxt;
      if (take_even) hold <= data_in;
    end
  end

  // A fresh pixel reloads the register even while draining, keeping valid high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      last_out  <= 1'b0;
    end else if (produce) begin
      valid_out <= 1'b1;
      data_out  <= (state == S_ODD) ? pair_mean : data_in;
      last_out  <= (state == S_ODD) ? last_in : 1'b1;
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end

  generate
    if (LINE_W != 0) begin : g_line_chk
      logic [CNT_W-1:0] px_cnt;
      logic             len_bad;

      assign len_bad = ({1'b0, px_cnt} + 1'b1) != (CNT_W + 1)'(LINE_W);

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          px_cnt   <= '0;
          line_err <= 1'b0;
        end else begin
          line_err <= 1'b0;
          if (accept) begin
            if (last_in) begin
              line_err <= len_bad;
              px_cnt   <= '0;
            end else if (px_cnt != '1) begin
              px_cnt <= px_cnt + 1'b1;
            end
          end
        end
      end
    end else begin : g_no_line_chk
      assign line_err = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_jmb_horz_decim_by_2.sv
// Directed and randomised-backpressure bench for the horizontal decimator,
// running a rounding/LINE_W=4 instance and a truncating/no-check instance side by side.
module tb_jmb_horz_decim_by_2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_in;
  logic [7:0] data_in;
  logic       last_in;
  logic       ready_in;

  logic       ready_out_a, valid_out_a, last_out_a, line_err_a;
  logic [7:0] data_out_a;
  logic       ready_out_b, valid_out_b, last_out_b, line_err_b;
  logic [7:0] data_out_b;

  int checks   = 0;
  int failures = 0;
  int errb_hits = 0;

  always #5 clk = ~clk;

  jmb_horz_decim_by_2 #(.DATA_W(8), .ROUND(1), .LINE_W(4), .CNT_W(12)) dut_a (
    .clock     (clk),
    .reset_n   (rst_n),
    .valid_in  (valid_in),
    .ready_out (ready_out_a),
    .data_in   (data_in),
    .last_in   (last_in),
    .valid_out (valid_out_a),
    .ready_in  (ready_in),
    .data_out  (data_out_a),
    .last_out  (last_out_a),
    .line_err  (line_err_a)
  );

  jmb_horz_decim_by_2 #(.DATA_W(8), .ROUND(0), .LINE_W(0), .CNT_W(12)) dut_b (
    .clock     (clk),
    .reset_n   (rst_n),
    .valid_in  (valid_in),
    .ready_out (ready_out_b),
    .data_in   (data_in),
    .last_in   (last_in),
    .valid_out (valid_out_b),
    .ready_in  (ready_in),
    .data_out  (data_out_b),
    .last_out  (last_out_b),
    .line_err  (line_err_b)
  );

  always @(negedge clk) if (line_err_b) errb_hits++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Offer one pixel from a falling edge and return 1 time unit after the edge that accepts it.
  task automatic send(input logic [7:0] px, input logic lst);
    int n = 0;
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = px;
    last_in  = lst;
    #1;
    while (!ready_out_a && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] d_rnd;
    logic [7:0] d_trn;
    logic       last;
  } exp_t;

  exp_t       q[$];
  logic [7:0] px_v[1000];
  logic       lst_v[1000];

  initial begin
    exp_t e;
    logic [7:0] held;
    logic       odd;
    int idx, cyc;

    rst_n    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    last_in  = 1'b0;
    ready_in = 1'b1;
    #1;
    check("rst_valid", valid_out_a, 0);
    check("rst_data", data_out_a, 0);
    check("rst_last", last_out_a, 0);
    check("rst_err", line_err_a, 0);
    check("rst_ready", ready_out_a, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 10,20,30,41(last): 15 then 36 (rounded) / 35 (truncated)
    send(8'd10, 1'b0);
    check("t1_no_out", valid_out_a, 0);
    send(8'd20, 1'b0);
    check("t1_v0", valid_out_a, 1);
    check("t1_d0", data_out_a, 15);
    check("t1_l0", last_out_a, 0);
    check("t1_d0_trunc", data_out_b, 15);
    send(8'd30, 1'b0);
    check("t1_drained", valid_out_a, 0);
    send(8'd41, 1'b1);
    check("t1_v1", valid_out_a, 1);
    check("t1_d1", data_out_a, 36);
    check("t1_l1", last_out_a, 1);
    check("t1_d1_trunc", data_out_b, 35);
    check("t1_len_ok", line_err_a, 0);
    idle();

    // Arithmetic edges
    send(8'd255, 1'b0);
    send(8'd255, 1'b1);
    check("t2_max", data_out_a, 255);
    check("t2_max_trunc", data_out_b, 255);
    check("t2_short_err", line_err_a, 1);
    idle();
    check("t2_err_pulse", line_err_a, 0);
    send(8'd0, 1'b0);
    send(8'd1, 1'b1);
    check("t2_round", data_out_a, 1);
    check("t2_trunc", data_out_b, 0);
    idle();

    // Odd-length line, then a fresh pair on the next line
    send(8'd8, 1'b0);
    send(8'd9, 1'b0);
    check("t3_d0", data_out_a, 9);
    check("t3_d0_trunc", data_out_b, 8);
    send(8'd100, 1'b1);
    check("t3_v1", valid_out_a, 1);
    check("t3_d1", data_out_a, 100);
    check("t3_l1", last_out_a, 1);
    check("t3_err", line_err_a, 1);
    idle();
    check("t3_err_once", line_err_a, 0);
    send(8'd2, 1'b0);
    send(8'd5, 1'b1);
    check("t3_fresh", data_out_a, 4);
    check("t3_fresh_trunc", data_out_b, 3);
    idle();

    // Backpressure: stalled output blocks input without losing it
    ready_in = 1'b0;
    send(8'd50, 1'b0);
    send(8'd60, 1'b0);
    check("t4_v", valid_out_a, 1);
    check("t4_d", data_out_a, 55);
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = 8'd70;
    last_in  = 1'b0;
    #1;
    check("t4_ready_low", ready_out_a, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("t4_hold_d", data_out_a, 55);
      check("t4_hold_v", valid_out_a, 1);
    end
    @(negedge clk);
    ready_in = 1'b1;
    #1;
    check("t4_ready_high", ready_out_a, 1);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    check("t4_drain", valid_out_a, 0);
    send(8'd80, 1'b1);
    check("t4_kept", data_out_a, 75);
    check("t4_kept_last", last_out_a, 1);
    check("t4_len_ok", line_err_a, 0);
    idle();

    // Random ready_in over 1000 pixels against a pairing model
    odd  = 1'b0;
    held = '0;
    for (int i = 0; i < 1000; i++) begin
      px_v[i]  = 8'($urandom_range(0, 255));
      lst_v[i] = ($urandom_range(0, 9) == 0) || (i == 999);
      if (!odd) begin
        if (lst_v[i]) begin
          e.d_rnd = px_v[i];
          e.d_trn = px_v[i];
          e.last  = 1'b1;
          q.push_back(e);
        end else begin
          held = px_v[i];
          odd  = 1'b1;
        end
      end else begin
        e.d_rnd = 8'((9'(held) + 9'(px_v[i]) + 9'd1) >> 1);
        e.d_trn = 8'((9'(held) + 9'(px_v[i])) >> 1);
        e.last  = lst_v[i];
        q.push_back(e);
        odd = 1'b0;
      end
    end
    idx = 0;
    cyc = 0;
    while ((idx < 1000 || q.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      ready_in = 1'($urandom_range(0, 1));
      if (idx < 1000) begin
        valid_in = 1'b1;
        data_in  = px_v[idx];
        last_in  = lst_v[idx];
      end else begin
        valid_in = 1'b0;
      end
      #1;
      if (valid_out_a && ready_in) begin
        if (q.size() == 0) begin
          check("rnd_extra", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("rnd_d", data_out_a, e.d_rnd);
          check("rnd_d_trunc", data_out_b, e.d_trn);
          check("rnd_last", last_out_a, e.last);
        end
      end
      if (valid_in && ready_out_a) idx++;
      @(posedge clk);
      cyc++;
    end
    #1;
    valid_in = 1'b0;
    ready_in = 1'b1;
    check("rnd_all_in", idx, 1000);
    check("rnd_all_out", q.size(), 0);
    idle();

    // Asynchronous reset while holding a pixel
    send(8'd200, 1'b0);
    send(8'd100, 1'b1);
    send(8'd50, 1'b0);
    check("t6_pre_d", data_out_a, 150);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_d", data_out_a, 0);
    check("t6_rst_l", last_out_a, 0);
    check("t6_rst_v", valid_out_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'd50, 1'b0);
    send(8'd70, 1'b1);
    check("t6_pair", data_out_a, 60);
    check("t6_pair_trunc", data_out_b, 60);
    check("t6_last", last_out_a, 1);
    check("t6_err", line_err_a, 1);
    idle();

    check("no_len_check_err", errb_hits, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
